// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory controller: load/store width encodings,
// controller state enum and the alignment-check helper.
package dmem_ctrl_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } load_funct3_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } dmem_state_t;

    // funct3[1:0] gives the access size for loads and stores alike
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_load_align.sv
// Selects the addressed byte/halfword from a cache word and sign- or
// zero-extends it according to the load width.
import dmem_ctrl_pkg::*;

module dmem_load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data = rdata;
        case (load_funct3_t'(funct3))
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   data = {24'h0, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data = {16'h0, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the load/store queue head and the data cache.
// One access at a time; result goes back to the LSQ and out on the CDB.
//
// state | meaning
// IDLE  | waiting for a load/store at the queue head
// BUSY  | cache request outstanding
// DONE  | response/broadcast cycle, back to IDLE next
// DRAIN | flushed while outstanding, wait for cache to finish
import dmem_ctrl_pkg::*;

module dmem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_ip,
    input  logic        lsq_read,
    input  logic        lsq_write,
    input  logic [31:0] lsq_addr,
    input  logic [2:0]  lsq_funct3,
    input  logic [3:0]  lsq_mbe,
    input  logic [31:0] lsq_wdata,
    input  logic [2:0]  lsq_tag,
    output logic        lsq_resp,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_mbe,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        cdb_valid,
    output logic [2:0]  cdb_tag,
    output logic [31:0] cdb_data,
    output logic        misaligned
);

    dmem_state_t state;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [3:0]  mbe_q;
    logic [31:0] wdata_q;
    logic [2:0]  tag_q;
    logic        is_read_q;
    logic [31:0] load_data;
    logic        req_active;

    dmem_load_align u_align (
        .rdata  (dmem_rdata),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    // cache request is a pure function of state so async reset drops it at once
    assign req_active   = (state == BUSY) || (state == DRAIN);
    assign dmem_read    = req_active & is_read_q;
    assign dmem_write   = req_active & ~is_read_q;
    assign dmem_address = {addr_q[31:2], 2'b00};
    assign dmem_wdata   = wdata_q << {addr_q[1:0], 3'b000};
    assign dmem_mbe     = is_read_q ? 4'hF : mbe_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            funct3_q   <= '0;
            mbe_q      <= '0;
            wdata_q    <= '0;
            tag_q      <= '0;
            is_read_q  <= 1'b0;
            lsq_resp   <= 1'b0;
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
            misaligned <= 1'b0;
        end else begin
            lsq_resp   <= 1'b0;
            cdb_valid  <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if ((lsq_read || lsq_write) && !flush_ip) begin
                        addr_q    <= lsq_addr;
                        funct3_q  <= lsq_funct3;
                        mbe_q     <= lsq_mbe;
                        wdata_q   <= lsq_wdata;
                        tag_q     <= lsq_tag;
                        is_read_q <= lsq_read;
                        if (is_misaligned(lsq_funct3, lsq_addr[1:0])) begin
                            state      <= DONE;
                            lsq_resp   <= 1'b1;
                            cdb_valid  <= 1'b1;
                            cdb_tag    <= lsq_tag;
                            cdb_data   <= '0;
                            misaligned <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_resp) begin
                        // a flush coinciding with the response still retires the head
                        state     <= DONE;
                        lsq_resp  <= 1'b1;
                        cdb_valid <= !flush_ip;
                        cdb_tag   <= tag_q;
                        cdb_data  <= is_read_q ? load_data : 32'h0;
                    end else if (flush_ip) begin
                        state <= DRAIN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    if (dmem_resp) begin
                        state    <= IDLE;
                        lsq_resp <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed cases plus randomized loads/stores
// with a behavioural cache, a reference model and a scoreboard monitor.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_ip = 1'b0;
    logic        lsq_read = 1'b0;
    logic        lsq_write = 1'b0;
    logic [31:0] lsq_addr = '0;
    logic [2:0]  lsq_funct3 = '0;
    logic [3:0]  lsq_mbe = '0;
    logic [31:0] lsq_wdata = '0;
    logic [2:0]  lsq_tag = '0;
    logic        lsq_resp;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_resp = 1'b0;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        misaligned;

    dmem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .flush_ip     (flush_ip),
        .lsq_read     (lsq_read),
        .lsq_write    (lsq_write),
        .lsq_addr     (lsq_addr),
        .lsq_funct3   (lsq_funct3),
        .lsq_mbe      (lsq_mbe),
        .lsq_wdata    (lsq_wdata),
        .lsq_tag      (lsq_tag),
        .lsq_resp     (lsq_resp),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_address (dmem_address),
        .dmem_wdata   (dmem_wdata),
        .dmem_mbe     (dmem_mbe),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .misaligned   (misaligned)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          valid;
        logic [2:0]  tag;
        logic [31:0] data;
        bit          mis;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % access_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int unsigned w;
        logic [7:0]  b;
        logic [15:0] h;
        w = rd / (32'd1 << (8 * (a % 4)));
        b = 8'(w % 256);
        h = 16'(w % 65536);
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b100:  return {24'h0, b};
            3'b001:  return 32'($signed(h));
            3'b101:  return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    // one complete LSQ-head access; k = cycle of cache response, f = flush cycle (0 = none)
    task automatic do_access(input bit rd, input logic [2:0] f3, input logic [31:0] a,
                             input logic [3:0] mbe, input logic [31:0] wd, input logic [2:0] tag,
                             input logic [31:0] rdata, input int k, input int f, input bit hold);
        exp_t e;
        bit   mis;
        mis = ref_misaligned(f3, a);
        @(posedge clk); #1;
        lsq_read   = rd;
        lsq_write  = !rd;
        lsq_addr   = a;
        lsq_funct3 = f3;
        lsq_mbe    = mbe;
        lsq_wdata  = wd;
        lsq_tag    = tag;
        e.cyc   = mis ? cyc + 1 : cyc + k + 1;
        e.valid = mis || (f == 0);
        e.tag   = tag;
        e.data  = (rd && !mis) ? ref_load(f3, a, rdata) : 32'h0;
        e.mis   = mis;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (!hold || mis) begin
            lsq_read  = 1'b0;
            lsq_write = 1'b0;
        end
        if (mis) begin
            check("no_cache_req", 32'({dmem_read, dmem_write}), 32'h0);
        end else begin
            for (int i = 1; i <= k; i++) begin
                check("dmem_read", 32'(dmem_read), 32'(rd));
                check("dmem_write", 32'(dmem_write), 32'(!rd));
                check("dmem_address", dmem_address, a & 32'hFFFF_FFFC);
                check("dmem_mbe", 32'(dmem_mbe), rd ? 32'hF : 32'(mbe));
                if (!rd) check("dmem_wdata", dmem_wdata, wd * (32'd1 << (8 * (a % 4))));
                flush_ip   = (i == f);
                dmem_resp  = (i == k);
                dmem_rdata = (i == k) ? rdata : $urandom;
                @(posedge clk); #1;
                flush_ip  = 1'b0;
                dmem_resp = 1'b0;
            end
        end
        lsq_read  = 1'b0;
        lsq_write = 1'b0;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (lsq_resp) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_lsq_resp: got 1 expected 0 (cyc=%0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("cdb_valid", 32'(cdb_valid), 32'(mon_e.valid));
                    check("misaligned", 32'(misaligned), 32'(mon_e.mis));
                    if (mon_e.valid) begin
                        check("cdb_tag", 32'(cdb_tag), 32'(mon_e.tag));
                        if (!mon_e.mis) check("cdb_data", cdb_data, mon_e.data);
                    end
                end
            end else if (cdb_valid || misaligned) begin
                n_tests++;
                n_fail++;
                $display("FAIL stray_cdb: got cdb_valid=%0b misaligned=%0b expected 0", cdb_valid, misaligned);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit          rd;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [3:0]  mbe;
        int          k;
        int          f;
        logic [2:0]  ld_f3 [5];
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({lsq_resp, dmem_read, dmem_write, cdb_valid, misaligned, cdb_tag, dmem_mbe}), 32'h0);
        check("reset_addr", dmem_address | dmem_wdata | cdb_data, 32'h0);
        rst = 1'b1;

        do_access(1, 3'b010, 32'h100, 4'h0, 32'h0, 3'd5, 32'hDEAD_BEEF, 3, 0, 0);
        do_access(1, 3'b000, 32'h203, 4'h0, 32'h0, 3'd1, 32'h80FF_FFFF, 1, 0, 0);
        do_access(1, 3'b100, 32'h203, 4'h0, 32'h0, 3'd2, 32'h80FF_FFFF, 2, 0, 1);
        do_access(1, 3'b101, 32'h202, 4'h0, 32'h0, 3'd3, 32'h1234_ABCD, 1, 0, 0);
        do_access(0, 3'b000, 32'h301, 4'b0010, 32'h0000_00AA, 3'd4, 32'h0, 3, 0, 0);
        do_access(1, 3'b010, 32'h102, 4'h0, 32'h0, 3'd6, 32'h0, 1, 0, 0);
        do_access(1, 3'b010, 32'h180, 4'h0, 32'h0, 3'd7, 32'h5555_AAAA, 5, 1, 0);
        do_access(1, 3'b001, 32'h182, 4'h0, 32'h0, 3'd0, 32'h8001_0000, 2, 2, 0);

        // async reset while the cache request is outstanding
        @(posedge clk); #1;
        lsq_read = 1'b1; lsq_addr = 32'h40; lsq_funct3 = 3'b010; lsq_tag = 3'd3;
        @(posedge clk); #1;
        lsq_read = 1'b0;
        check("busy_before_reset", 32'(dmem_read), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("async_reset_ctrl",
              32'({lsq_resp, dmem_read, dmem_write, cdb_valid, misaligned, cdb_tag, dmem_mbe}), 32'h0);
        check("async_reset_addr", dmem_address | dmem_wdata | cdb_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        do_access(1, 3'b010, 32'h44, 4'h0, 32'h0, 3'd2, 32'hCAFE_F00D, 2, 0, 0);

        for (int n = 0; n < 200; n++) begin
            rd = $urandom_range(0, 1) == 1;
            a  = {$urandom_range(0, 32'hFFFF), 2'b00} | 32'($urandom_range(0, 3));
            if (rd) begin
                f3  = ld_f3[$urandom_range(0, 4)];
                mbe = 4'h0;
            end else begin
                f3  = 3'($urandom_range(0, 2));
                mbe = 4'(((1 << access_size(f3)) - 1) << (a % 4));
            end
            k = $urandom_range(1, 4);
            f = ($urandom_range(0, 3) == 0) ? $urandom_range(1, k) : 0;
            do_access(rd, f3, a, mbe, $urandom, 3'($urandom_range(0, 7)), $urandom,
                      k, f, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller directly downstream of the load/store queue. It accepts one load or store at a time from the queue head, performs the word-aligned data-cache handshake, and aligns and extends load data. It returns the one-cycle memory response the queue uses to retire its head, and broadcasts the completed ROB tag and result on the CDB. It also drains any in-flight cache access safely when a flush is in progress.

## Interface
Parameters: none (widths fixed by rv32i_types/tomasula_types).
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- flush_ip  in  1  pipeline flush in progress
- lsq_read  in  1  queue head requests a load
- lsq_write  in  1  queue head requests a store
- lsq_addr  in  32  byte address (src1 + offset)
- lsq_funct3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- lsq_mbe  in  4  store byte mask, already shifted by addr[1:0]
- lsq_wdata  in  32  store data, unshifted, from the register named by wdata_reg
- lsq_tag  in  3  ROB tag of the head entry
- lsq_resp  out  1  one-cycle pulse: head access finished (drives LSQ data_mem_resp)
- dmem_read / dmem_write  out  1  cache request, level, held until dmem_resp
- dmem_address  out  32  {addr[31:2], 2'b00}
- dmem_wdata  out  32  store data shifted left by 8*addr[1:0]
- dmem_mbe  out  4  byte enables (1111 for reads)
- dmem_rdata  in  32  cache read data, valid with dmem_resp
- dmem_resp  in  1  cache done, one cycle
- cdb_valid  out  1  one-cycle broadcast
- cdb_tag  out  3  ROB tag broadcast
- cdb_data  out  32  aligned load result; 0 for stores
- misaligned  out  1  one-cycle pulse with cdb_valid for a misaligned access

## Operation
- FSM states: IDLE, BUSY, DONE, DRAIN.
- Reset: state IDLE. All outputs 0, including all request registers.
- IDLE
  - If lsq_read|lsq_write and ~flush_ip: latch addr, funct3, mbe, wdata, tag, and rd/wr.
  - Misalignment is defined as: H/HU/SH with addr[0]=1, or W with addr[1:0]≠0.
  - Misaligned access: go to DONE with no cache access.
  - Aligned access: go to BUSY.
  - If both lsq_read and lsq_write are set, read wins.
- BUSY
  - dmem_read or dmem_write asserted from the latched copy.
  - flush_ip goes to DRAIN.
  - Otherwise, dmem_resp captures aligned data and goes to DONE.
  - If flush_ip and dmem_resp arrive in the same cycle, go to DONE and treat it as flushed: cdb_valid is suppressed.
- DONE
  - lsq_resp=1.
  - cdb_valid=1 unless flush_ip or a flush was captured. cdb_tag is the latched tag.
  - misaligned=1 if the access was misaligned.
  - Next state: IDLE.
- DRAIN
  - Keep the cache request asserted until dmem_resp.
  - On dmem_resp: lsq_resp=1, no CDB broadcast, go to IDLE.
- Load alignment uses byte offset o=addr[1:0]:
  - B: sign-extend rdata[8o+7:8o].
  - BU: zero-extend rdata[8o+7:8o].
  - H/HU: rdata[8o+15:8o], sign- or zero-extended.
  - W: rdata unchanged.
- Stores: cdb_data=0. dmem_mbe=lsq_mbe.

## Timing
- Registered outputs: lsq_resp, cdb_*, misaligned. The dmem_* outputs come from the latched request.
- Aligned access, request sampled at cycle 0:
  - Cache request asserted from cycle 1.
  - With dmem_resp at cycle k≥1, lsq_resp and cdb_valid fire at cycle k+1.
  - Minimum latency is therefore 2 cycles.
- Misaligned access: lsq_resp and cdb_valid at cycle 1.
- Back-to-back: the request is re-sampled in the IDLE cycle following DONE. The LSQ advances its head on lsq_resp, so there is no double issue.
- Requests present in BUSY, DONE, or DRAIN are ignored, not queued.
- Async reset mid-access drops the cache request immediately.

## Structure
- Add load funct3 encodings to rv32i_types and the dmem_state_t enum to tomasula_types.
- Combinational sub-module dmem_load_align(rdata, offset, funct3 → data).

## Test plan
- LW at 0x100, rdata=0xDEADBEEF, tag=5, dmem_resp 3 cycles after request → cdb_valid one cycle with tag 5, data 0xDEADBEEF; lsq_resp same cycle; dmem_address 0x100.
- LB at 0x203, rdata=0x80FFFFFF → cdb_data 0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x202, rdata=0x1234ABCD → 0x00001234.
- SB at 0x301, wdata=0x000000AA, mbe=0010 → dmem_wdata 0x0000AA00, dmem_mbe 0010, dmem_write held until resp; cdb_data 0, cdb_valid 1.
- LW at 0x102 → no dmem request; at cycle 1, misaligned=1, cdb_valid=1, lsq_resp=1.
- flush_ip raised in BUSY, dmem_resp 4 cycles later → dmem_read held throughout; lsq_resp pulses on completion; cdb_valid never asserts; returns to IDLE.
- rst low mid-BUSY → all outputs 0 asynchronously; after release, the next LW completes normally.
